blinker_mode_ctrl: RTL and testbench
====================================

Name: blinker_mode_ctrl

Overview:
- Push-button front end that drives the LED blinker's enable, sel0 and sel1 inputs; sits directly upstream of the blinker.
- Synchronises and debounces a raw pushbutton input, then classifies each press as short or long:
  - Short press: steps the blink-rate mode 1Hz -> 10Hz -> 50Hz -> 100Hz -> 1Hz.
  - Long press: toggles enable.
- Runs on the same 25 kHz system clock as the blinker.

Parameters:
- DEBOUNCE_CYCLES, 500: cycles btn_sync must differ stably from btn_db before btn_db updates (20 ms at 25 kHz); minimum 2.
- LONG_PRESS_CYCLES, 25000: cycles btn_db must stay high in S_DOWN before the press counts as long (1 s); must be > 1.
- ENABLE_RST, 1: reset value of enable.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset_n  input  1  asynchronous active-low reset; asserts immediately, releases on clk.
- btn_raw  input  1  raw pushbutton, active-high, asynchronous, bouncy.
- enable  output  1  registered; to blinker enable.
- sel0  output  1  equals mode[1]; to blinker sel0.
- sel1  output  1  equals mode[0]; to blinker sel1.
- mode  output  2  registered; 0=1Hz, 1=10Hz, 2=50Hz, 3=100Hz.
- mode_changed  output  1  registered one-cycle pulse whenever mode changes.

Behaviour:
- Reset (reset_n=0, asynchronous), all regardless of clk:
  - sync flops = 0, btn_db = 0, db_cnt = 0, hold_cnt = 0, state = S_UP.
  - mode = 0, enable = ENABLE_RST, mode_changed = 0.
- Synchroniser: two flops, btn_raw -> btn_s1 -> btn_sync.
- Debounce:
  - If btn_sync == btn_db: db_cnt <= 0.
  - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1: btn_db <= btn_sync and db_cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches btn_db.
  - Latency from a stable btn_raw edge to the btn_db edge: 2 + DEBOUNCE_CYCLES cycles.
- FSM (three states, advanced on btn_db):
  - S_UP: on btn_db == 1 -> S_DOWN, hold_cnt <= 0.
  - S_DOWN: hold_cnt increments each cycle.
    - If btn_db == 0 (short press): mode <= mode + 1 (2-bit wrap, 3 -> 0), mode_changed <= 1, -> S_UP.
    - Else if hold_cnt == LONG_PRESS_CYCLES-1: enable <= ~enable, -> S_LONG.
    - If both conditions are true in the same cycle, release wins: short press, enable unchanged.
  - S_LONG: on btn_db == 0 -> S_UP; mode is unchanged.
- Event spacing: each short press advances mode exactly once; each long press toggles enable exactly once, at the threshold, not on release.
- Output timing:
  - mode, enable and mode_changed update one cycle after the deciding btn_db sample.
  - sel0/sel1 are combinational from the mode register.
  - mode_changed is 0 in every cycle except the one following a mode update.
- Counter widths:
  - hold_cnt: $clog2(LONG_PRESS_CYCLES) bits, saturating; it never wraps while in S_DOWN.
  - db_cnt: $clog2(DEBOUNCE_CYCLES) bits.
- Reset mid-press: all state clears; after release the button must read low in S_UP before a new press is recognised. A button held through reset is seen as a new press once btn_db rises.
- enable does not gate mode changes; mode steps even while enable == 0.

Optional Feature:
- Macro: BLINKER_MODE_DOWN_BTN_EN.
- Defined:
  - Adds port btn_dn_raw (input, 1 bit) with its own synchroniser, debouncer and S_UP/S_DOWN/S_LONG FSM.
  - Short press on the down button: mode <= mode - 1 (wrap 0 -> 3) and pulses mode_changed.
  - Long press on the down button: no action (no enable toggle).
  - Up and down short-press events in the same cycle: mode unchanged, mode_changed stays 0.
- Undefined: the port is absent and behaviour is as above.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ENABLE_RST=1):
- Reset: reset_n=0 mid-clock -> mode=0, sel0=0, sel1=0, enable=1, mode_changed=0 immediately, without waiting for a clk edge.
- Bounce: btn_raw high for 3 cycles, low for 2, high for 3, then low -> btn_db never rises, mode stays 0.
- Short presses: four presses, each high 10 cycles / low 10 cycles -> mode goes 1, 2, 3, 0; (sel0,sel1) = (0,1), (1,0), (1,1), (0,0); four single-cycle mode_changed pulses.
- Long press: btn_raw high for 40 cycles -> enable goes 1 to 0 exactly 2+4+20+1 cycles after the rising edge; mode stays 0 on release. A second long press restores enable=1.
- Reset mid-press: reset_n pulsed low while btn_raw has been high 15 cycles -> no mode or enable change. After release and a fresh 10-cycle press -> mode=1.
- BLINKER_MODE_DOWN_BTN_EN: from mode=0, down press -> mode=3. Up and down presses with identical timing -> mode unchanged, no mode_changed pulse.

Source files
------------

// File: rtl/blinker_mode_ctrl.sv
// Pushbutton front end for the LED blinker: short press steps the blink-rate mode, long press toggles enable.
// Define BLINKER_MODE_DOWN_BTN_EN to add a second button (btn_dn_raw) whose short press steps the mode down.

module blinker_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_db
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            btn_s1;
    logic            btn_sync;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1   <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_s1   <= btn_raw;
            btn_sync <= btn_s1;
        end
    end

    // btn_db only follows btn_sync after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_sync == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
endmodule

module blinker_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 500,
    parameter int LONG_PRESS_CYCLES = 25000,
    parameter int ENABLE_RST        = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_raw,
`ifdef BLINKER_MODE_DOWN_BTN_EN
    input  logic       btn_dn_raw,
`endif
    output logic       enable,
    output logic       sel0,
    output logic       sel1,
    output logic [1:0] mode,
    output logic       mode_changed
);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic ENABLE_INIT = (ENABLE_RST != 0);

    typedef enum logic [1:0] {
        S_UP,
        S_DOWN,
        S_LONG
    } press_state_t;

    press_state_t      state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              btn_db;
    logic              up_short;
    logic              dn_short;

    blinker_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up_db (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .btn_db (btn_db)
    );

    // A release seen in S_DOWN is a short press, even on the threshold cycle
    assign up_short = (state == S_DOWN) && !btn_db;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_UP;
            hold_cnt <= '0;
            enable   <= ENABLE_INIT;
        end else begin
            case (state)
                S_UP: begin
                    if (btn_db) begin
                        state    <= S_DOWN;
                        hold_cnt <= '0;
                    end
                end
                S_DOWN: begin
                    if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (!btn_db) begin
                        state <= S_UP;
                    end else if (hold_cnt == HOLD_LAST) begin
                        enable <= ~enable;
                        state  <= S_LONG;
                    end
                end
                S_LONG: begin
                    if (!btn_db) begin
                        state <= S_UP;
                    end
                end
                default: state <= S_UP;
            endcase
        end
    end

`ifdef BLINKER_MODE_DOWN_BTN_EN
    press_state_t      dn_state;
    logic [HOLD_W-1:0] dn_hold_cnt;
    logic              dn_btn_db;

    blinker_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dn_db (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_dn_raw),
        .btn_db (dn_btn_db)
    );

    assign dn_short = (dn_state == S_DOWN) && !dn_btn_db;

    // Long presses on the down button are tracked only so their release is not taken as a short press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dn_state    <= S_UP;
            dn_hold_cnt <= '0;
        end else begin
            case (dn_state)
                S_UP: begin
                    if (dn_btn_db) begin
                        dn_state    <= S_DOWN;
                        dn_hold_cnt <= '0;
                    end
                end
                S_DOWN: begin
                    if (dn_hold_cnt != '1) begin
                        dn_hold_cnt <= dn_hold_cnt + 1'b1;
                    end
                    if (!dn_btn_db) begin
                        dn_state <= S_UP;
                    end else if (dn_hold_cnt == HOLD_LAST) begin
                        dn_state <= S_LONG;
                    end
                end
                S_LONG: begin
                    if (!dn_btn_db) begin
                        dn_state <= S_UP;
                    end
                end
                default: dn_state <= S_UP;
            endcase
        end
    end
`else
    assign dn_short = 1'b0;
`endif

    // Simultaneous up and down short presses cancel out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode         <= 2'd0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            if (up_short && !dn_short) begin
                mode         <= mode + 2'd1;
                mode_changed <= 1'b1;
            end else if (dn_short && !up_short) begin
                mode         <= mode - 2'd1;
                mode_changed <= 1'b1;
            end
        end
    end

    assign sel0 = mode[1];
    assign sel1 = mode[0];
endmodule

// File: tb/tb_blinker_mode_ctrl.sv
// Bench for blinker_mode_ctrl: vector table, corner sequences and random presses against a press-length model.
// Define BLINKER_MODE_DOWN_BTN_EN to also exercise the down button.

module tb_blinker_mode_ctrl;
    localparam int DB = 4;
    localparam int LP = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       btn_raw = 1'b0;
    logic       btn_dn_raw = 1'b0;
    logic       enable;
    logic       sel0;
    logic       sel1;
    logic [1:0] mode;
    logic       mode_changed;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [1:0] exp_mode;
        logic       exp_en;
        logic [3:0] exp_pulses;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    blinker_mode_ctrl #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .ENABLE_RST       (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
`ifdef BLINKER_MODE_DOWN_BTN_EN
        .btn_dn_raw  (btn_dn_raw),
`endif
        .enable      (enable),
        .sel0        (sel0),
        .sel1        (sel1),
        .mode        (mode),
        .mode_changed(mode_changed)
    );

    // Model: a debounced level flips once the last DB synchronised samples all disagree with it;
    // a debounced high run of length <= LP is a short press, a longer one toggles enable at LP+1.
    logic [31:0] hist [2];
    bit          m_db [2];
    bit          m_db_prev [2];
    int          run_len [2];
    logic [1:0]  exp_mode;
    logic        exp_enable;
    logic        exp_changed;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            hist[b]      = '0;
            m_db[b]      = 1'b0;
            m_db_prev[b] = 1'b0;
            run_len[b]   = 0;
        end
        exp_mode    = 2'd0;
        exp_enable  = 1'b1;
        exp_changed = 1'b0;
    endtask

    task automatic model_step();
        bit   short_evt [2];
        bit   all_diff;
        logic sample;
        exp_changed = 1'b0;
        for (int b = 0; b < 2; b++) begin
            short_evt[b] = 1'b0;
            if (m_db[b]) begin
                run_len[b] = run_len[b] + 1;
                if (b == 0 && run_len[b] == LP + 1) exp_enable = ~exp_enable;
            end else begin
                if (m_db_prev[b] && run_len[b] <= LP) short_evt[b] = 1'b1;
                run_len[b] = 0;
            end
            sample  = (b == 0) ? btn_raw : btn_dn_raw;
            hist[b] = {hist[b][30:0], sample};
            all_diff = 1'b1;
            for (int k = 2; k <= DB + 1; k++) begin
                if (hist[b][k] == m_db[b]) all_diff = 1'b0;
            end
            m_db_prev[b] = m_db[b];
            if (all_diff) m_db[b] = ~m_db[b];
        end
        if (short_evt[0] && !short_evt[1]) begin
            exp_mode    = exp_mode + 2'd1;
            exp_changed = 1'b1;
        end else if (short_evt[1] && !short_evt[0]) begin
            exp_mode    = exp_mode - 2'd1;
            exp_changed = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({mode, enable, mode_changed, sel0, sel1} !==
                {exp_mode, exp_enable, exp_changed, exp_mode[1], exp_mode[0]}) begin
                errors++;
                $display("[TB] FAIL model_cycle t=%0t got mode=%0d en=%b chg=%b sel0=%b sel1=%b want mode=%0d en=%b chg=%b",
                         $time, mode, enable, mode_changed, sel0, sel1, exp_mode, exp_enable, exp_changed);
            end
            if (mode_changed === 1'b1) pulses++;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int hi, input int lo, input logic up, input logic dn);
        btn_raw    = up;
        btn_dn_raw = dn;
        repeat (hi) @(negedge clk);
        btn_raw    = 1'b0;
        btn_dn_raw = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   hi;
        int   lo;
        logic up;
        logic dn;

        vecs[0]  = '{8'd10, 8'd10, 2'd1, 1'b1, 4'd1};
        vecs[1]  = '{8'd10, 8'd10, 2'd2, 1'b1, 4'd1};
        vecs[2]  = '{8'd10, 8'd10, 2'd3, 1'b1, 4'd1};
        vecs[3]  = '{8'd10, 8'd10, 2'd0, 1'b1, 4'd1};
        vecs[4]  = '{8'd3,  8'd10, 2'd0, 1'b1, 4'd0};
        vecs[5]  = '{8'd40, 8'd10, 2'd0, 1'b0, 4'd0};
        vecs[6]  = '{8'd5,  8'd10, 2'd1, 1'b0, 4'd1};
        vecs[7]  = '{8'd20, 8'd10, 2'd2, 1'b0, 4'd1};
        vecs[8]  = '{8'd21, 8'd10, 2'd2, 1'b1, 4'd0};
        vecs[9]  = '{8'd4,  8'd10, 2'd3, 1'b1, 4'd1};
        vecs[10] = '{8'd2,  8'd10, 2'd3, 1'b1, 4'd0};
        vecs[11] = '{8'd30, 8'd10, 2'd3, 1'b0, 4'd0};

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_mode", int'(mode), 0);
        check_output("rst_enable", int'(enable), 1);
        check_output("rst_changed", int'(mode_changed), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            pulses = 0;
            apply_stimulus(int'(vecs[i].hi), int'(vecs[i].lo), 1'b1, 1'b0);
            check_output($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].exp_mode));
            check_output($sformatf("vec%0d_sel", i), int'({sel0, sel1}), int'(vecs[i].exp_mode));
            check_output($sformatf("vec%0d_enable", i), int'(enable), int'(vecs[i].exp_en));
            check_output($sformatf("vec%0d_pulses", i), pulses, int'(vecs[i].exp_pulses));
        end

        // Asynchronous reset taken mid-cycle, checked before any further clock edge
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_rst_mode", int'(mode), 0);
        check_output("async_rst_sel0", int'(sel0), 0);
        check_output("async_rst_sel1", int'(sel1), 0);
        check_output("async_rst_enable", int'(enable), 1);
        check_output("async_rst_changed", int'(mode_changed), 0);
        @(negedge clk);
        reset_n = 1'b1;

        pulses = 0;
        btn_raw = 1'b1; repeat (3) @(negedge clk);
        btn_raw = 1'b0; repeat (2) @(negedge clk);
        btn_raw = 1'b1; repeat (3) @(negedge clk);
        btn_raw = 1'b0; repeat (12) @(negedge clk);
        check_output("bounce_mode", int'(mode), 0);
        check_output("bounce_pulses", pulses, 0);

        pulses = 0;
        btn_raw = 1'b1;
        repeat (26) @(negedge clk);
        check_output("long_before_edge", int'(enable), 1);
        @(negedge clk);
        check_output("long_at_edge", int'(enable), 0);
        repeat (13) @(negedge clk);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        check_output("long_release_mode", int'(mode), 0);
        check_output("long_release_pulses", pulses, 0);
        apply_stimulus(40, 10, 1'b1, 1'b0);
        check_output("long2_enable", int'(enable), 1);
        check_output("long2_mode", int'(mode), 0);

        pulses = 0;
        btn_raw = 1'b1;
        repeat (15) @(negedge clk);
        reset_n = 1'b0;
        btn_raw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check_output("midrst_mode", int'(mode), 0);
        check_output("midrst_enable", int'(enable), 1);
        check_output("midrst_pulses", pulses, 0);
        apply_stimulus(10, 10, 1'b1, 1'b0);
        check_output("midrst_fresh_mode", int'(mode), 1);
        apply_stimulus(10, 10, 1'b1, 1'b0);
        check_output("pre_hold_mode", int'(mode), 2);

        // Button held through reset must register as one new short press once released
        pulses = 0;
        btn_raw = 1'b1;
        repeat (15) @(negedge clk);
        reset_pulse();
        repeat (10) @(negedge clk);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        check_output("held_rst_mode", int'(mode), 1);
        check_output("held_rst_pulses", pulses, 1);

`ifdef BLINKER_MODE_DOWN_BTN_EN
        reset_pulse();
        pulses = 0;
        apply_stimulus(10, 10, 1'b0, 1'b1);
        check_output("down_mode", int'(mode), 3);
        check_output("down_pulses", pulses, 1);
        pulses = 0;
        apply_stimulus(10, 10, 1'b1, 1'b1);
        check_output("both_mode", int'(mode), 3);
        check_output("both_pulses", pulses, 0);
        apply_stimulus(40, 10, 1'b0, 1'b1);
        check_output("down_long_enable", int'(enable), 1);
        check_output("down_long_mode", int'(mode), 3);
`endif

        for (int i = 0; i < 60; i++) begin
            hi = $urandom_range(1, 30);
            lo = $urandom_range(1, 14);
            up = 1'b1;
            dn = 1'b0;
`ifdef BLINKER_MODE_DOWN_BTN_EN
            case ($urandom_range(0, 3))
                0: begin up = 1'b0; dn = 1'b1; end
                1: begin up = 1'b1; dn = 1'b1; end
                default: begin up = 1'b1; dn = 1'b0; end
            endcase
`endif
            if ($urandom_range(0, 9) == 0) begin
                #3 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            apply_stimulus(hi, lo, up, dn);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
